// File: rtl/sine_table_loader_pkg.sv
// sine_table_loader_pkg: shared loader constants and FSM state type
package sine_table_loader_pkg;
  localparam int SINE_TABLE_ADDR_WIDTH = 14;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, WRITE, DONE} loaderState_t;
endpackage

// File: rtl/sine_table_byte_assembler.sv
// sine_table_byte_assembler: byte handshake and low/high byte pairing into 16-bit words
module sine_table_byte_assembler (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Start,
  input  logic        i_Expecting,
  input  logic        i_HighPhase,
  input  logic        i_ByteValid,
  input  logic [7:0]  i_Byte,
  output logic        o_ByteReady,
  output logic        o_LowAccept,
  output logic        o_HighAccept,
  output logic [15:0] o_Word
);
  logic [7:0] lowByte;
  logic       accept;
  // Start outranks a same-cycle byte so an abort never swallows data
  assign o_ByteReady  = i_Expecting & ~i_Start;
  assign accept       = o_ByteReady & i_ByteValid;
  assign o_LowAccept  = accept & ~i_HighPhase;
  assign o_HighAccept = accept & i_HighPhase;
  assign o_Word       = {i_Byte, lowByte};
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n || i_Start) lowByte <= '0;
    else if (o_LowAccept) lowByte <= i_Byte;
  end
endmodule

// File: rtl/sine_table_loader.sv
// sine_table_loader: streams host bytes into the sine table, one write per 16-bit word.
// Optional running checksum output enabled by SINE_TABLE_LOADER_CHECKSUM_EN.
module sine_table_loader
  import sine_table_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = SINE_TABLE_ADDR_WIDTH
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Start,
  input  logic                  i_ByteValid,
  input  logic [7:0]            i_Byte,
  output logic                  o_ByteReady,
  output logic                  o_SineTableWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_SineTableWriteAddress,
  output logic [15:0]           o_SineTableWriteValue,
  output logic                  o_Busy,
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
  output logic [15:0]           o_Checksum,
`endif
  output logic                  o_Done
);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
  loaderState_t          state;
  logic [ADDR_WIDTH-1:0] counter;
  logic                  writeStrobe;
  logic                  lowAccept;
  logic                  highAccept;
  logic [15:0]           word;
  sine_table_byte_assembler assembler (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_Start      (i_Start),
    .i_Expecting  (state == LOW || state == HIGH),
    .i_HighPhase  (state == HIGH),
    .i_ByteValid  (i_ByteValid),
    .i_Byte       (i_Byte),
    .o_ByteReady  (o_ByteReady),
    .o_LowAccept  (lowAccept),
    .o_HighAccept (highAccept),
    .o_Word       (word)
  );
  // A Start landing on the WRITE cycle suppresses that cycle's strobe
  assign o_SineTableWriteEnable = writeStrobe & ~i_Start;
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state                   <= IDLE;
      counter                 <= '0;
      writeStrobe             <= 1'b0;
      o_SineTableWriteAddress <= '0;
      o_SineTableWriteValue   <= '0;
      o_Busy                  <= 1'b0;
      o_Done                  <= 1'b0;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
      o_Checksum              <= '0;
`endif
    end else begin
      writeStrobe <= 1'b0;
      if (i_Start) begin
        state   <= LOW;
        counter <= '0;
        o_Busy  <= 1'b1;
        o_Done  <= 1'b0;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        o_Checksum <= '0;
`endif
      end else begin
        case (state)
          LOW: if (lowAccept) state <= HIGH;
          HIGH: if (highAccept) begin
            state                   <= WRITE;
            writeStrobe             <= 1'b1;
            o_SineTableWriteAddress <= counter;
            o_SineTableWriteValue   <= word;
          end
          WRITE: begin
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
            o_Checksum <= o_Checksum + o_SineTableWriteValue;
`endif
            if (counter == LastAddr) begin
              state  <= DONE;
              o_Busy <= 1'b0;
              o_Done <= 1'b1;
            end else begin
              state   <= LOW;
              counter <= counter + ADDR_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sine_table_loader.sv
// tb_sine_table_loader: directed scoreboard bench for sine_table_loader
module tb_sine_table_loader;
  logic        i_Clock = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_Start = 1'b0;
  logic        i_ByteValid = 1'b0;
  logic [7:0]  i_Byte = 8'h00;
  logic        o_ByteReady;
  logic        o_SineTableWriteEnable;
  logic [13:0] o_SineTableWriteAddress;
  logic [15:0] o_SineTableWriteValue;
  logic        o_Busy;
  logic        o_Done;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
  logic [15:0] o_Checksum;
`endif
  int          checks = 0;
  int          failures = 0;
  logic [29:0] expQ[$];
  logic [29:0] monExp;

  sine_table_loader #(.ADDR_WIDTH(14)) dut (
    .i_Clock                 (i_Clock),
    .i_Reset_n               (i_Reset_n),
    .i_Start                 (i_Start),
    .i_ByteValid             (i_ByteValid),
    .i_Byte                  (i_Byte),
    .o_ByteReady             (o_ByteReady),
    .o_SineTableWriteEnable  (o_SineTableWriteEnable),
    .o_SineTableWriteAddress (o_SineTableWriteAddress),
    .o_SineTableWriteValue   (o_SineTableWriteValue),
    .o_Busy                  (o_Busy),
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    .o_Checksum              (o_Checksum),
`endif
    .o_Done                  (o_Done)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write
  always @(negedge i_Clock) begin
    if (o_SineTableWriteEnable === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_strobe", {2'b0, o_SineTableWriteAddress, o_SineTableWriteValue}, 32'hFFFF_FFFF);
      end else begin
        monExp = expQ.pop_front();
        check("strobe_addr_value", {2'b0, o_SineTableWriteAddress, o_SineTableWriteValue}, {2'b0, monExp});
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    i_ByteValid = 1'b1;
    i_Byte = b;
    for (int t = 0; t < 50 && !acc; t++) begin
      #1 acc = o_ByteReady;
      @(negedge i_Clock);
    end
    i_ByteValid = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseStart();
    i_Start = 1'b1;
    @(negedge i_Clock);
    i_Start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_we"}, o_SineTableWriteEnable, 0);
    check({tag, "_ready"}, o_ByteReady, 0);
    check({tag, "_busy"}, o_Busy, 0);
    check({tag, "_done"}, o_Done, 0);
    check({tag, "_addr"}, o_SineTableWriteAddress, 0);
    check({tag, "_value"}, o_SineTableWriteValue, 0);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, o_Checksum, 0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    repeat (2) @(negedge i_Clock);
    #1 checkAllZero("reset");
    i_Reset_n = 1'b1;
    // Single word: strobe the cycle after the high byte is accepted
    pulseStart();
    #1 check("start_busy", o_Busy, 1);
    check("start_ready", o_ByteReady, 1);
    expQ.push_back({14'h0000, 16'h1234});
    sendByte(8'h34);
    sendByte(8'h12);
    #1 check("latency_strobe", o_SineTableWriteEnable, 1);
    @(negedge i_Clock);
    // Abort with a pending low byte
    sendByte(8'h56);
    pulseStart();
    expQ.push_back({14'h0000, 16'h9A78});
    sendByte(8'h78);
    sendByte(8'h9A);
    #1 check("abort_restart_strobe", o_SineTableWriteEnable, 1);
    // Start collides with a valid byte during WRITE
    i_Start = 1'b1;
    i_ByteValid = 1'b1;
    i_Byte = 8'hAA;
    #1 check("start_blocks_ready", o_ByteReady, 0);
    check("start_blocks_strobe", o_SineTableWriteEnable, 0);
    @(negedge i_Clock);
    i_Start = 1'b0;
    i_ByteValid = 1'b0;
    expQ.push_back({14'h0000, 16'h2211});
    sendByte(8'h11);
    sendByte(8'h22);
    #1 check("collision_strobe", o_SineTableWriteEnable, 1);
    @(negedge i_Clock);
    // Reset during HIGH
    pulseStart();
    sendByte(8'h01);
    i_ByteValid = 1'b1;
    i_Byte = 8'h02;
    i_Reset_n = 1'b0;
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    #1 checkAllZero("midreset");
    repeat (5) @(negedge i_Clock);
    #1 check("post_reset_ready", o_ByteReady, 0);
    check("post_reset_busy", o_Busy, 0);
    i_ByteValid = 1'b0;
    // Bursty stream with random idle gaps
    pulseStart();
    for (int k = 0; k < 40; k++) begin
      w = 16'hA5C3 ^ 16'(k * 16'h0111);
      expQ.push_back({14'(k), w});
      if ($urandom_range(0, 1) == 1) @(negedge i_Clock);
      sendByte(w[7:0]);
      if ($urandom_range(0, 1) == 1) @(negedge i_Clock);
      sendByte(w[15:8]);
    end
    @(negedge i_Clock);
    #1 check("partial_busy", o_Busy, 1);
    check("partial_done", o_Done, 0);
    // Full continuous load, word equals address
    pulseStart();
    for (int a = 0; a < 16384; a++) begin
      w = 16'(a);
      expQ.push_back({14'(a), w});
      sendByte(w[7:0]);
      sendByte(w[15:8]);
    end
    #1 check("last_strobe", o_SineTableWriteEnable, 1);
    check("last_addr", o_SineTableWriteAddress, 14'h3FFF);
    @(negedge i_Clock);
    #1 check("full_done", o_Done, 1);
    check("full_busy", o_Busy, 0);
    check("full_ready", o_ByteReady, 0);
    check("full_no_strobe", o_SineTableWriteEnable, 0);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    check("full_checksum", o_Checksum, 16'hE000);
`endif
    repeat (3) @(negedge i_Clock);
    #1 check("done_sticky", o_Done, 1);
    check("scoreboard_drained", expQ.size(), 0);
    pulseStart();
    #1 check("restart_clears_done", o_Done, 0);
    check("restart_busy", o_Busy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sine_table_loader.md
SINE_TABLE_LOADER -- requirements
Module: sine_table_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, sine table address width; table depth is 2**ADDR_WIDTH words.
REQ-002 i_Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 i_Reset_n  input  1  synchronous, active-low reset.
REQ-004 i_Start  input  1  single-cycle pulse that begins a table load at address 0.
REQ-005 i_ByteValid  input  1  host byte-stream valid.
REQ-006 i_Byte  input  8  host byte-stream data; words arrive low byte first.
REQ-007 o_ByteReady  output  1  loader accepts i_Byte on any cycle where i_ByteValid and o_ByteReady are both high.
REQ-008 o_SineTableWriteEnable  output  1  one-cycle write strobe to the waveform generator's sine table write port.
REQ-009 o_SineTableWriteAddress  output  ADDR_WIDTH  write address, valid while the strobe is high.
REQ-010 o_SineTableWriteValue  output  16  write data, valid while the strobe is high.
REQ-011 o_Busy  output  1  high while a load is in progress.
REQ-012 o_Done  output  1  sticky completion flag, cleared by i_Start or reset.
REQ-013 o_Checksum  output  16  running checksum, present only with the checksum macro (REQ-028).

Function
REQ-014 States: IDLE, LOW, HIGH, WRITE, DONE.
REQ-015 IDLE transitions to LOW on i_Start; the address counter clears to 0.
REQ-016 LOW: the accepted byte is latched as the word's low byte, then the state moves to HIGH.
REQ-017 HIGH: the accepted byte completes the 16-bit word, then the state moves to WRITE.
REQ-018 WRITE lasts exactly one cycle, with o_SineTableWriteEnable=1, address equal to the counter, and value equal to {high, low}.
REQ-019 From WRITE, the state goes to LOW with counter+1, or to DONE if the counter equals 2**ADDR_WIDTH-1.
REQ-020 Latency: the write strobe asserts in the cycle after the high byte is accepted.
REQ-021 Full table load takes 3 cycles per word minimum, which is 49152 cycles at ADDR_WIDTH=14 with a continuous stream.
REQ-022 o_ByteReady = (state is LOW or HIGH) and not i_Start; it is low during IDLE, WRITE, and DONE.
REQ-023 i_Start in any state, including mid-load, aborts the current load:
- partial byte discarded
- counter cleared to 0
- state goes to LOW
- o_Done cleared
- no write strobe in that cycle
REQ-024 When i_Start and i_ByteValid arrive in the same cycle, Start wins and the byte is not accepted.
REQ-025 DONE holds o_Done=1 and o_Busy=0 until i_Start or reset.
REQ-026 o_Busy = state is LOW, HIGH, or WRITE.
REQ-027 The address counter never wraps, because the terminal address forces DONE.

Configuration
REQ-028 With macro SINE_TABLE_LOADER_CHECKSUM_EN defined:
- o_Checksum exists.
- It is the mod-2**16 sum of every written word.
- It is cleared on i_Start and on reset.
- It updates in the WRITE cycle and is visible the next cycle.
- Without the macro, o_Checksum and its adder are absent.

Reset
REQ-029 While i_Reset_n=0 at a clock edge:
- state goes to IDLE
- counter, byte latch, and o_Checksum are set to 0
- all outputs are 0, including o_ByteReady, o_SineTableWriteEnable, o_Busy, and o_Done
REQ-030 Reset mid-load abandons the load with no further write strobes; table contents are not cleared.

Structure
REQ-031 The state enum and the default SINE_TABLE_ADDR_WIDTH=14 constant SHALL live in the shared synth package/header next to the voice/operator definitions.
REQ-032 One sub-module is natural: sine_table_byte_assembler (byte-to-word pairing with handshake); the FSM and counter stay in the top level.

Verification
REQ-033 Scenario: reset, then Start, then bytes 0x34,0x12 -> one strobe, address 0x0000, value 0x1234, issued the cycle after 0x12 is accepted.
REQ-034 Scenario: continuous stream of 32768 bytes encoding word=address -> 16384 strobes, last address 0x3FFF, o_Done=1 and o_Busy=0 the cycle after the last strobe; checksum 0xE000 with the macro.
REQ-035 Scenario: i_ByteValid toggled randomly at 50% -> identical writes to the continuous case, and no byte accepted while o_ByteReady=0.
REQ-036 Scenario: Start after 3 bytes (one word written, low byte pending) -> no further strobe from the pending byte; the next strobe is at address 0 with the new word.
REQ-037 Scenario: i_Reset_n=0 for one cycle mid-HIGH -> all outputs 0 the next cycle, and bytes are ignored until Start.
REQ-038 Scenario: i_Start and i_ByteValid in the same cycle with byte 0xAA -> byte not accepted, and the next accepted byte becomes the low byte of address 0.
